// File: rtl/blinker_pattern_decoder.sv
// Decodes the blinker LED bus into IDLE/HAZARD/LEFT/RIGHT with lock, error and 7-seg glyph.
// Ports: ADC_CLK_10, RESET (sync, high), LED_IN[9:0] in; MODE, LOCKED, ERR, FRAME_EVT, HEX0 out. Option: BLINK_STALL_DETECT_EN.
module blinker_pattern_decoder #(
  parameter int LOCK_FRAMES  = 3,
  parameter int IDLE_CYCLES  = 8,
  parameter int STALL_CYCLES = 16
) (
  input  logic       ADC_CLK_10,
  input  logic       RESET,
  input  logic [9:0] LED_IN,
  output logic [2:0] MODE,
  output logic       LOCKED,
  output logic       ERR,
  output logic       FRAME_EVT,
  output logic [7:0] HEX0
);
  localparam int CW = $clog2(LOCK_FRAMES + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  localparam logic [2:0] M_NONE = 3'd0;
  localparam logic [2:0] M_IDLE = 3'd1;
  localparam logic [2:0] M_HAZ  = 3'd2;
  localparam logic [2:0] M_LEFT = 3'd3;
  localparam logic [2:0] M_RGT  = 3'd4;

  typedef enum logic [1:0] {ACQ, LOCK, IDLE, ERRS} state_t;

  state_t        state_q, state_d;
  logic [5:0]    frame, prev_q;
  logic [2:0]    cand_q, cand_d, tmode;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          evt_q, evt, idle_hit;
  logic [7:0]    hex_q, hex_d;
  logic          unused_bits;

  assign unused_bits = ^LED_IN[6:3];
  assign frame = {LED_IN[9:7], LED_IN[2:0]};
  assign evt   = frame != prev_q;

  always_comb begin
    tmode = M_NONE;
    case ({prev_q, frame})
      {6'b000000, 6'b001000}: tmode = M_LEFT;
      {6'b001000, 6'b011000}: tmode = M_LEFT;
      {6'b011000, 6'b111000}: tmode = M_LEFT;
      {6'b111000, 6'b000000}: tmode = M_LEFT;
      {6'b000000, 6'b000100}: tmode = M_RGT;
      {6'b000100, 6'b000110}: tmode = M_RGT;
      {6'b000110, 6'b000111}: tmode = M_RGT;
      {6'b000111, 6'b000000}: tmode = M_RGT;
      {6'b000000, 6'b111111}: tmode = M_HAZ;
      {6'b111111, 6'b000000}: tmode = M_HAZ;
      default:                tmode = M_NONE;
    endcase
  end

  // Fires only on the edge the zero-run first reaches the threshold.
  assign idle_hit = (frame == '0) && (idle_q == IW'(IDLE_CYCLES - 1));

  always_comb begin
    idle_d = '0;
    if (frame == '0)
      idle_d = (idle_q == IW'(IDLE_CYCLES)) ? idle_q : idle_q + 1'b1;
  end

`ifdef BLINK_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          stall_hit;

  always_comb begin
    stall_d = '0;
    if (state_q == LOCK && !evt)
      stall_d = (stall_q == SW'(STALL_CYCLES)) ? stall_q : stall_q + 1'b1;
  end

  // An all-off stall is left to the idle rule.
  assign stall_hit = (state_q == LOCK) && !evt &&
                     (stall_d == SW'(STALL_CYCLES)) && (frame != '0);

  always_ff @(posedge ADC_CLK_10) begin
    if (RESET) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  logic stall_hit;
  logic unused_stall;
  assign stall_hit    = 1'b0;
  assign unused_stall = ^STALL_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    if (idle_hit) begin
      state_d = IDLE;
      cand_d  = M_NONE;
      cnt_d   = '0;
    end else if (stall_hit) begin
      state_d = ERRS;
    end else if (evt && state_q != ERRS) begin
      if (tmode == M_NONE) begin
        state_d = ERRS;
      end else begin
        case (state_q)
          ACQ: begin
            if (tmode == cand_q) begin
              if (cnt_q != CW'(LOCK_FRAMES)) cnt_d = cnt_q + 1'b1;
            end else begin
              cand_d = tmode;
              cnt_d  = CW'(1);
            end
            if (cnt_d == CW'(LOCK_FRAMES)) state_d = LOCK;
          end
          LOCK: begin
            if (tmode != cand_q) begin
              state_d = ACQ;
              cand_d  = tmode;
              cnt_d   = CW'(1);
            end
          end
          IDLE: begin
            state_d = ACQ;
            cand_d  = tmode;
            cnt_d   = CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mode_d   = M_NONE;
    locked_d = 1'b0;
    err_d    = 1'b0;
    hex_d    = 8'hFF;
    unique case (1'b1)
      state_d == LOCK: begin
        mode_d   = cand_d;
        locked_d = 1'b1;
      end
      state_d == IDLE: begin
        mode_d   = M_IDLE;
        locked_d = 1'b1;
      end
      state_d == ERRS: err_d = 1'b1;
      default: ;
    endcase
    unique case (1'b1)
      err_d:            hex_d = 8'h86;
      mode_d == M_IDLE: hex_d = 8'hBF;
      mode_d == M_HAZ:  hex_d = 8'h89;
      mode_d == M_LEFT: hex_d = 8'hC7;
      mode_d == M_RGT:  hex_d = 8'hAF;
      default:          hex_d = 8'hFF;
    endcase
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (RESET) begin
      state_q  <= ACQ;
      prev_q   <= '0;
      cand_q   <= M_NONE;
      cnt_q    <= '0;
      idle_q   <= '0;
      mode_q   <= M_NONE;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      evt_q    <= 1'b0;
      hex_q    <= 8'hFF;
    end else begin
      state_q  <= state_d;
      if (evt) prev_q <= frame;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      mode_q   <= mode_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      evt_q    <= evt;
      hex_q    <= hex_d;
    end
  end

  assign MODE      = mode_q;
  assign LOCKED    = locked_q;
  assign ERR       = err_q;
  assign FRAME_EVT = evt_q;
  assign HEX0      = hex_q;
endmodule

// File: tb/tb_blinker_pattern_decoder.sv
// Self-checking bench for blinker_pattern_decoder: directed frames,
// sequence-table model compared every cycle, plus literal checkpoints.
module tb_blinker_pattern_decoder;
  localparam int LOCK_FRAMES  = 3;
  localparam int IDLE_CYCLES  = 8;
  localparam int STALL_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] led = '0;
  logic [2:0] mode;
  logic       locked, err, fevt;
  logic [7:0] hex;

  blinker_pattern_decoder #(
    .LOCK_FRAMES(LOCK_FRAMES),
    .IDLE_CYCLES(IDLE_CYCLES),
    .STALL_CYCLES(STALL_CYCLES)
  ) dut (
    .ADC_CLK_10(clk),
    .RESET(rst),
    .LED_IN(led),
    .MODE(mode),
    .LOCKED(locked),
    .ERR(err),
    .FRAME_EVT(fevt),
    .HEX0(hex)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fe   = 0;
  bit chk_en = 0;

  // model state
  logic [5:0] m_prev;
  int m_run, m_cand, m_cnt, m_lmode, m_stall;
  bit m_idle, m_err, m_evt;

  logic [5:0] seq_l [4] = '{6'o00, 6'o10, 6'o30, 6'o70};
  logic [5:0] seq_r [4] = '{6'o00, 6'o04, 6'o06, 6'o07};

  function automatic int legal(logic [5:0] p, logic [5:0] c);
    for (int i = 0; i < 4; i++) begin
      if (p == seq_l[i] && c == seq_l[(i + 1) % 4]) return 3;
      if (p == seq_r[i] && c == seq_r[(i + 1) % 4]) return 4;
    end
    if ((p == 6'o00 && c == 6'o77) || (p == 6'o77 && c == 6'o00)) return 2;
    return 0;
  endfunction

  function automatic int exp_mode();
    if (m_err) return 0;
    if (m_idle) return 1;
    return m_lmode;
  endfunction

  function automatic int exp_hex();
    if (m_err) return 8'h86;
    case (exp_mode())
      1: return 8'hBF;
      2: return 8'h89;
      3: return 8'hC7;
      4: return 8'hAF;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic chk(string name, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_edge(input logic r, input logic [9:0] l);
    logic [5:0] f;
    int  tm;
    bit  ev, hit, was_lock;
    if (r) begin
      m_prev = '0; m_run = 0; m_cand = 0; m_cnt = 0; m_lmode = 0;
      m_stall = 0; m_idle = 0; m_err = 0; m_evt = 0;
      return;
    end
    f = {l[9:7], l[2:0]};
    ev = (f != m_prev);
    tm = ev ? legal(m_prev, f) : 0;
    hit = (f == 0) && (m_run == IDLE_CYCLES - 1);
    was_lock = (m_lmode != 0) && !m_err && !m_idle;
    if (f != 0) m_run = 0;
    else if (m_run < IDLE_CYCLES) m_run++;
    m_evt = ev;
    if (hit) begin
      m_idle = 1; m_err = 0; m_lmode = 0; m_cand = 0; m_cnt = 0;
    end else if (ev && !m_err) begin
      if (tm == 0) begin
        m_err = 1; m_idle = 0; m_lmode = 0;
      end else if (m_idle) begin
        m_idle = 0; m_cand = tm; m_cnt = 1;
      end else if (m_lmode != 0) begin
        if (tm != m_lmode) begin
          m_lmode = 0; m_cand = tm; m_cnt = 1;
        end
      end else begin
        if (tm == m_cand) m_cnt++;
        else begin m_cand = tm; m_cnt = 1; end
        if (m_cnt >= LOCK_FRAMES) m_lmode = m_cand;
      end
    end
`ifdef BLINK_STALL_DETECT_EN
    if (was_lock && !ev) begin
      if (m_stall < STALL_CYCLES) m_stall++;
      if (m_stall == STALL_CYCLES && f != 0 && !hit) begin
        m_err = 1; m_lmode = 0;
      end
    end else begin
      m_stall = 0;
    end
`else
    m_stall = was_lock ? 0 : 0;
`endif
    if (ev) m_prev = f;
  endtask

  task automatic step(input logic r, input logic [9:0] l);
    rst = r;
    led = l;
    @(posedge clk);
    #1;
    model_edge(r, l);
    chk_en = 1;
    if (fevt) n_fe++;
  endtask

  task automatic hold(input logic [9:0] l, input int n);
    for (int i = 0; i < n; i++) step(1'b0, l);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mode", int'(mode), exp_mode());
      chk("locked", int'(locked), int'(m_idle || (m_lmode != 0 && !m_err)));
      chk("err", int'(err), int'(m_err));
      chk("frame_evt", int'(fevt), int'(m_evt));
      chk("hex", int'(hex), exp_hex());
    end
  end

  initial begin
    step(1'b1, '0);
    step(1'b1, '0);
    chk("rst_mode", mode, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_hex", hex, 8'hFF);
    // middle bits must be ignored
    hold(10'h078, 7);
    chk("idle_pre", mode, 0);
    hold(10'h000, 1);
    chk("idle_mode", mode, 1);
    chk("idle_locked", locked, 1);
    chk("idle_hex", hex, 8'hBF);
    hold(10'h000, 2);

    n_fe = 0;
    hold(10'h080, 4);
    hold(10'h180, 4);
    step(1'b0, 10'h380);
    chk("left_mode", mode, 3);
    chk("left_locked", locked, 1);
    chk("left_hex", hex, 8'hC7);
    hold(10'h380, 3);
    chk("left_evts", n_fe, 3);

    hold(10'h000, 4);
    hold(10'h004, 4);
    hold(10'h006, 4);
    step(1'b0, 10'h007);
    chk("right_mode", mode, 4);
    chk("right_hex", hex, 8'hAF);
    hold(10'h007, 3);
    hold(10'h000, 4);
    step(1'b0, 10'h387);
    chk("haz_unlock_mode", mode, 0);
    chk("haz_unlock_lk", locked, 0);
    hold(10'h387, 3);
    hold(10'h000, 4);
    step(1'b0, 10'h387);
    chk("haz_mode", mode, 2);
    chk("haz_hex", hex, 8'h89);
    hold(10'h387, 3);

    step(1'b1, 10'h387);
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_lk", locked, 0);
    chk("mid_rst_hex", hex, 8'hFF);
    step(1'b0, 10'h387);
    hold(10'h387, 3);
    hold(10'h000, 4);
    chk("relock_wait", mode, 0);
    step(1'b0, 10'h387);
    chk("relock_mode", mode, 2);
    hold(10'h387, 3);

    hold(10'h000, 4);
    hold(10'h080, 4);
    hold(10'h180, 4);
    step(1'b0, 10'h380);
    chk("left2_mode", mode, 3);
    hold(10'h380, 3);
    step(1'b0, 10'h101);
    chk("ill_err", err, 1);
    chk("ill_mode", mode, 0);
    chk("ill_hex", hex, 8'h86);
    hold(10'h101, 3);
    hold(10'h080, 4);
    hold(10'h387, 4);
    hold(10'h000, 7);
    chk("err_sticky", err, 1);
    step(1'b0, 10'h000);
    chk("err_clear", err, 0);
    chk("err_idle_mode", mode, 1);

    hold(10'h080, 4);
    hold(10'h180, 4);
    hold(10'h380, 4);
    hold(10'h000, 4);
    hold(10'h080, 4);
    hold(10'h180, 20);
`ifdef BLINK_STALL_DETECT_EN
    chk("stall_err", err, 1);
`else
    chk("stall_mode", mode, 3);
    chk("stall_err", err, 0);
`endif
    hold(10'h000, 10);
    chk("final_idle", mode, 1);

    @(posedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/blinker_pattern_decoder.md
Name: blinker_pattern_decoder

Overview:
- Receive-side counterpart of the tail-light blinker controller: watches the 10-bit LED pattern the controller drives and decodes which mode is active (IDLE, HAZARD, LEFT, RIGHT).
- Reports the decoded mode, a lock flag, an error flag and a 7-segment glyph.
- Sits beside the controller on the LEDR bus as a self-check/monitor.
- Only LED_IN[9:7] (left group) and LED_IN[2:0] (right group) are significant; LED_IN[6:3] is ignored.

Parameters:
- LOCK_FRAMES, 3: consecutive legal frame transitions of one mode required to lock (>=1).
- IDLE_CYCLES, 8: consecutive all-off cycles that declare IDLE (>=2).
- STALL_CYCLES, 16: cycles without a frame change that flag a stall (optional feature only).

Ports:
- ADC_CLK_10  input   1   system clock; all logic on the rising edge.
- RESET       input   1   synchronous, active-high reset.
- LED_IN      input   10  LED pattern from the blinker controller, same clock domain.
- MODE        output  3   0=NONE, 1=IDLE, 2=HAZARD, 3=LEFT, 4=RIGHT.
- LOCKED      output  1   MODE is a confirmed decode.
- ERR         output  1   illegal pattern seen; sticky until idle recovery or reset.
- FRAME_EVT   output  1   one-cycle pulse per frame change.
- HEX0        output  8   active-low {dp,g,f,e,d,c,b,a}; one glyph per decode state, listed under Behaviour.

Behaviour:
- Frame definition: frame = {LED_IN[9:7], LED_IN[2:0]}. Register prev_q holds the last accepted frame.
- Event: frame != prev_q at a clock edge. On an event, prev_q <= frame.
- Outputs are registered. An LED_IN change sampled at edge N is visible on outputs after edge N (1-cycle latency).
- Legal transition sequences (frame written as 6 bits):
  - LEFT: 000000 -> 001000 -> 011000 -> 111000 -> 000000.
  - RIGHT: 000000 -> 000100 -> 000110 -> 000111 -> 000000.
  - HAZARD: 000000 <-> 111111.
  - Every other (prev_q, frame) pair is illegal. Each legal pair maps to exactly one mode.
- FSM states: ACQ, LOCK, IDLE, ERRS. Reset value: ACQ.
- Reset state of all registers: MODE=0, LOCKED=0, ERR=0, FRAME_EVT=0, HEX0=8'hFF, prev_q=0, candidate=NONE, count=0, idle counter=0.
- ACQ, legal event:
  - Transition mode equals candidate: count++.
  - Otherwise: candidate <= transition mode, count <= 1.
  - When count reaches LOCK_FRAMES: go to LOCK, MODE <= candidate, LOCKED <= 1.
- LOCK:
  - Legal event of the current mode: stay.
  - Legal event of a different mode: go to ACQ with candidate <= that mode, count <= 1, MODE <= 0, LOCKED <= 0.
- Illegal event in ACQ, LOCK or IDLE: go to ERRS with ERR <= 1, MODE <= 0, LOCKED <= 0.
- ERRS: events are ignored. Exit only via idle recovery or RESET.
- Idle counter:
  - Counts consecutive cycles with frame == 0. Clears on any cycle with frame != 0.
  - Saturates at IDLE_CYCLES.
  - The edge at which it reaches IDLE_CYCLES, from any state: go to IDLE, MODE <= 1, LOCKED <= 1, ERR <= 0, count <= 0, candidate <= NONE.
- IDLE: a legal event from 000000 goes to ACQ with candidate <= that mode, count <= 1, MODE <= 0, LOCKED <= 0.
- Simultaneous idle-count completion and event cannot occur: an event to 000000 restarts the idle count at 1.
- HEX0 glyph per state:
  - NONE/unlocked: 8'hFF (blank).
  - IDLE: 8'hBF ('-').
  - HAZARD: 8'h89 ('H').
  - LEFT: 8'hC7 ('L').
  - RIGHT: 8'hAF ('r').
  - ERRS: 8'h86 ('E').
- RESET mid-operation returns all registers to their reset values on the next edge, regardless of LED_IN.
- Counter widths are $clog2(param+1). No wrap-around: all counters saturate.

Optional Feature:
- Macro: BLINK_STALL_DETECT_EN.
- Defined: in LOCK with MODE in {HAZARD, LEFT, RIGHT}, a stall counter counts cycles since the last event.
  - Reaching STALL_CYCLES with frame != 0: go to ERRS, ERR <= 1.
  - Stalls with frame == 0 are handled by the idle rule instead.
- Undefined: no stall counter; a frozen non-zero frame holds the locked mode indefinitely.

Test Plan:
- Reset/idle: RESET=1 for 2 cycles, then LED_IN=0 for 10 cycles -> outputs at reset values, then MODE=1, LOCKED=1, HEX0=8'hBF after the 8th zero cycle.
- Left lock: drive frames 001000, 011000, 111000, each 4 cycles -> FRAME_EVT pulses 3 times; LOCKED=1, MODE=3, HEX0=8'hC7 one cycle after the 3rd event.
- Right then hazard switch: lock RIGHT (MODE=4), then drive 000000, 111111 -> on 111111, LOCKED=0, MODE=0; after 3 alternations, MODE=2, HEX0=8'h89.
- Illegal frame: while locked LEFT, drive 010001 -> ERR=1, MODE=0, HEX0=8'h86; ERR holds through further patterns until LED_IN=0 for 8 cycles, then ERR=0, MODE=1.
- Reset mid-operation: assert RESET for 1 cycle while locked HAZARD -> next edge MODE=0, LOCKED=0, HEX0=8'hFF; relock requires 3 fresh legal events.
- Stall (BLINK_STALL_DETECT_EN defined): lock LEFT, hold 011000 for 16 cycles -> ERR=1; with the macro undefined, MODE stays 3.
